// File: rtl/mvau_wmem_sched.sv
// Weight-memory sequencer for one MVAU bank: issues weight addresses and input-buffer
// indices per SIMD beat, filling the input buffer on fold 0 and replaying it afterwards.
module mvau_wmem_sched #(
    parameter int SF           = 2,
    parameter int NF           = 2,
    parameter int WMEM_ADDR_BW = 4,
    parameter int SF_BW        = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_v,
    output logic                    in_rdy,
    output logic [SF_BW-1:0]        ib_addr,
    output logic                    ib_wr,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    out_v,
    input  logic                    out_rdy,
    output logic                    out_fold_last,
    output logic                    out_vec_last,
    output logic                    busy
);

    localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SF_BW-1:0]        SF_MAX = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0]        NF_MAX = NF_BW'(NF - 1);
    localparam logic [WMEM_ADDR_BW-1:0] SF_W   = WMEM_ADDR_BW'(SF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_REPLAY
    } state_t;

    state_t                  state, state_nxt;
    logic [SF_BW-1:0]        sf, sf_nxt;
    logic [NF_BW-1:0]        nf, nf_nxt;
    logic                    advance;
    logic                    issue;
    logic                    sf_last;
    logic                    nf_last;
    logic [WMEM_ADDR_BW-1:0] addr_calc;

    // Handshake, issue decision and next counter/state values
    always_comb begin
        state_nxt = state;
        sf_nxt    = sf;
        nf_nxt    = nf;
        advance   = !out_v || out_rdy;
        in_rdy    = aresetn && (state != S_REPLAY) && advance;
        issue     = (state == S_REPLAY) ? advance : (in_v && in_rdy);
        ib_wr     = in_v && in_rdy;
        ib_addr   = sf;
        busy      = (state != S_IDLE) || out_v;
        sf_last   = (sf == SF_MAX);
        nf_last   = (nf == NF_MAX);
        addr_calc = WMEM_ADDR_BW'(nf) * SF_W + WMEM_ADDR_BW'(sf);
        if (issue) begin
            if (sf_last) begin
                sf_nxt = '0;
                if (nf_last) begin
                    nf_nxt    = '0;
                    state_nxt = S_IDLE;
                end else begin
                    nf_nxt    = nf + 1'b1;
                    state_nxt = S_REPLAY;
                end
            end else begin
                sf_nxt    = sf + 1'b1;
                state_nxt = (nf == '0) ? S_FILL : S_REPLAY;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address and flags only move on issue, so a stall re-reads the same word
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sf            <= '0;
            nf            <= '0;
            wmem_addr     <= '0;
            out_v         <= 1'b0;
            out_fold_last <= 1'b0;
            out_vec_last  <= 1'b0;
        end else begin
            sf <= sf_nxt;
            nf <= nf_nxt;
            if (issue) begin
                wmem_addr     <= addr_calc;
                out_fold_last <= sf_last;
                out_vec_last  <= sf_last && nf_last;
                out_v         <= 1'b1;
            end else if (out_rdy) begin
                out_v <= 1'b0;
            end
        end
    end

endmodule
